// File: rtl/onchip_wr_pkg.sv
`default_nettype none
// ============================================================================
// Package  : onchip_wr_pkg
// Purpose  : Shared constants and state encoding for the on-chip memory
//            stream writer.
// Revision : 1.0 - initial release
// ============================================================================
package onchip_wr_pkg;

    localparam int IN_W      = 32;
    localparam int LINE_W    = 128;
    localparam int LANES     = LINE_W / IN_W;
    localparam int BE_W      = LINE_W / 8;
    localparam int ADDR_W    = 8;
    localparam int MAX_LINES = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

endpackage : onchip_wr_pkg
`default_nettype wire

// File: rtl/onchip_wr_line_packer.sv
`default_nettype none
// ============================================================================
// Module   : onchip_wr_line_packer
// Purpose  : Packs narrow sink beats into one memory line with byte mask.
//            ONCHIP_WR_BYTESWAP_EN byte-reverses each beat before packing.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_wr_line_packer #(
    parameter int IN_W   = onchip_wr_pkg::IN_W,
    parameter int LINE_W = onchip_wr_pkg::LINE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                beat_en,
    input  logic [IN_W-1:0]     beat_data,
    output logic                line_full,
    output logic [LINE_W-1:0]   line_data,
    output logic [LINE_W/8-1:0] line_be
);

    localparam int LANES  = LINE_W / IN_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BPL    = IN_W / 8;

    logic [LANE_W-1:0]   r_lane;
    logic [LINE_W-1:0]   r_data;
    logic [LINE_W/8-1:0] r_be;
    logic [IN_W-1:0]     w_beat;

    always_comb begin
`ifdef ONCHIP_WR_BYTESWAP_EN
        w_beat = '0;
        for (int b = 0; b < BPL; b++) begin
            w_beat[8*b +: 8] = beat_data[8*(BPL-1-b) +: 8];
        end
`else
        w_beat = beat_data;
`endif
    end

    // Unwritten lanes stay zero with their mask bits clear until the next clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= '0;
            r_data <= '0;
            r_be   <= '0;
        end else if (clear) begin
            r_lane <= '0;
            r_data <= '0;
            r_be   <= '0;
        end else if (beat_en) begin
            r_data[r_lane*IN_W +: IN_W] <= w_beat;
            r_be[r_lane*BPL +: BPL]     <= '1;
            r_lane                      <= r_lane + 1'b1;
        end
    end

    assign line_full = (r_lane == LANE_W'(LANES - 1));
    assign line_data = r_data;
    assign line_be   = r_be;

endmodule : onchip_wr_line_packer
`default_nettype wire

// File: rtl/onchip_mem_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_stream_writer
// Purpose  : Avalon-ST sink that packs beats into 128-bit lines and writes
//            them to consecutive on-chip memory addresses from a base.
//            Optional beat byteswap via ONCHIP_WR_BYTESWAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_writer #(
    parameter int IN_W   = onchip_wr_pkg::IN_W,
    parameter int LINE_W = onchip_wr_pkg::LINE_W,
    parameter int ADDR_W = onchip_wr_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                snk_valid,
    output logic                snk_ready,
    input  logic [IN_W-1:0]     snk_data,
    input  logic                snk_endofpacket,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [LINE_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [LINE_W-1:0]   mem_writedata,
    output logic                mem_clken,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     lines_written,
    output logic                wrapped
);

    import onchip_wr_pkg::*;

    wr_state_t         r_state;
    wr_state_t         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_lines;
    logic              r_wrapped;
    logic              r_last;

    logic w_start;
    logic w_accept;
    logic w_line_end;
    logic w_clear;
    logic w_line_full;

    assign w_start    = (r_state == IDLE) && start;
    assign w_accept   = (r_state == FILL) && snk_valid;
    assign w_line_end = w_accept && (w_line_full || snk_endofpacket);
    assign w_clear    = w_start || (r_state == WRITE);

    onchip_wr_line_packer #(
        .IN_W   (IN_W),
        .LINE_W (LINE_W)
    ) u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (w_clear),
        .beat_en   (w_accept),
        .beat_data (snk_data),
        .line_full (w_line_full),
        .line_data (mem_writedata),
        .line_be   (mem_byteenable)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FILL;
            FILL:    if (w_line_end) w_next = WRITE;
            WRITE:   w_next = r_last ? DONE : FILL;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Address, counters and flags; the line count sticks at its maximum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_lines   <= '0;
            r_wrapped <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_start) begin
            r_addr    <= base_addr;
            r_lines   <= '0;
            r_wrapped <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_line_end) begin
            r_last    <= snk_endofpacket;
        end else if (r_state == WRITE) begin
            r_addr <= r_addr + 1'b1;
            if (r_addr == '1) begin
                r_wrapped <= 1'b1;
            end
            if (r_lines != '1) begin
                r_lines <= r_lines + 1'b1;
            end
        end
    end

    assign snk_ready      = (r_state == FILL);
    assign mem_chipselect = (r_state == WRITE);
    assign mem_write      = (r_state == WRITE);
    assign mem_address    = r_addr;
    assign mem_clken      = 1'b1;
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign lines_written  = r_lines;
    assign wrapped        = r_wrapped;

endmodule : onchip_mem_stream_writer
`default_nettype wire

// File: tb/tb_onchip_mem_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_stream_writer
// Purpose  : Directed self-checking bench for onchip_mem_stream_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_writer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   base_addr = '0;
    logic         snk_valid = 1'b0;
    logic         snk_ready;
    logic [31:0]  snk_data = '0;
    logic         snk_eop = 1'b0;
    logic [7:0]   mem_address;
    logic [15:0]  mem_byteenable;
    logic         mem_chipselect;
    logic         mem_write;
    logic [127:0] mem_writedata;
    logic         mem_clken;
    logic         busy;
    logic         done;
    logic [8:0]   lines_written;
    logic         wrapped;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   wa[$];
    logic [127:0] wd[$];
    logic [15:0]  wb[$];
    int           done_cnt  = 0;
    int           rdy_viol  = 0;
    int           cs_viol   = 0;

    always #5 clk = ~clk;

    onchip_mem_stream_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .snk_valid       (snk_valid),
        .snk_ready       (snk_ready),
        .snk_data        (snk_data),
        .snk_endofpacket (snk_eop),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .busy            (busy),
        .done            (done),
        .lines_written   (lines_written),
        .wrapped         (wrapped)
    );

    always @(negedge clk) begin
        if (mem_write) begin
            wa.push_back(mem_address);
            wd.push_back(mem_writedata);
            wb.push_back(mem_byteenable);
            if (snk_ready) rdy_viol++;
        end
        if (mem_chipselect != mem_write) cs_viol++;
        if (done) done_cnt++;
    end

    function automatic logic [31:0] ex(input logic [31:0] d);
`ifdef ONCHIP_WR_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wb.delete();
        done_cnt = 0; rdy_viol = 0;
    endtask

    task automatic do_start(input logic [7:0] b);
        start = 1'b1; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic eop, input int gap);
        int n = 0;
        snk_valid = 1'b1; snk_data = d; snk_eop = eop;
        @(negedge clk);
        while (!snk_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("beat_accept", 1'b0, 1'b1);
        @(posedge clk); #1;
        snk_valid = 1'b0; snk_eop = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string tag, input logic [8:0] exp_lines, input logic exp_wrap);
        int n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_lines"}, lines_written, exp_lines);
        check({tag, "_wrapped"}, wrapped, exp_wrap);
        @(posedge clk); #1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_write", mem_write, 1'b0);
        check("rst_cs", mem_chipselect, 1'b0);
        check("rst_clken", mem_clken, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", snk_ready, 1'b0);
        check("rst_lines", lines_written, 9'd0);
        check("rst_addr", mem_address, 8'h00);
        check("rst_be", mem_byteenable, 16'h0000);
        check("rst_data", mem_writedata, 128'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Full lines; eop on lane 3 of the second line
        clear_log();
        do_start(8'h10);
        for (int i = 0; i < 8; i++) send_beat(32'(i), (i == 7), 0);
        wait_done("full", 9'd2, 1'b0);
        check("full_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("full_a0", wa[0], 8'h10);
            check("full_d0", wd[0], {ex(32'h3), ex(32'h2), ex(32'h1), ex(32'h0)});
            check("full_b0", wb[0], 16'hFFFF);
            check("full_a1", wa[1], 8'h11);
            check("full_d1", wd[1], {ex(32'h7), ex(32'h6), ex(32'h5), ex(32'h4)});
            check("full_b1", wb[1], 16'hFFFF);
        end

        // Partial final line
        clear_log();
        do_start(8'h00);
        for (int i = 0; i < 6; i++) send_beat(32'hA000_0100 + 32'(i), (i == 5), 0);
        wait_done("part", 9'd2, 1'b0);
        check("part_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("part_a1", wa[1], 8'h01);
            check("part_b1", wb[1], 16'h00FF);
            check("part_d1", wd[1], {64'h0, ex(32'hA000_0105), ex(32'hA000_0104)});
        end

        // Address wrap
        clear_log();
        do_start(8'hFF);
        for (int i = 0; i < 8; i++) send_beat(32'hC0DE_0000 + 32'(i), (i == 7), 0);
        wait_done("wrap", 9'd2, 1'b1);
        check("wrap_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("wrap_a0", wa[0], 8'hFF);
            check("wrap_a1", wa[1], 8'h00);
        end

        // Gaps in valid and an ignored start mid-transfer
        clear_log();
        do_start(8'h20);
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hBEEF_0010 + 32'(i), (i == 7), 1);
            if (i == 2) do_start(8'hEE);
        end
        wait_done("gap", 9'd2, 1'b0);
        check("gap_nwr", wa.size(), 2);
        check("gap_ready_in_write", rdy_viol, 0);
        if (wa.size() == 2) begin
            check("gap_a0", wa[0], 8'h20);
            check("gap_a1", wa[1], 8'h21);
            check("gap_d0", wd[0], {ex(32'hBEEF_0013), ex(32'hBEEF_0012),
                                    ex(32'hBEEF_0011), ex(32'hBEEF_0010)});
            check("gap_d1", wd[1], {ex(32'hBEEF_0017), ex(32'hBEEF_0016),
                                    ex(32'hBEEF_0015), ex(32'hBEEF_0014)});
        end

        // Reset mid-operation
        clear_log();
        do_start(8'h30);
        send_beat(32'h1111_1111, 1'b0, 0);
        send_beat(32'h2222_2222, 1'b0, 0);
        reset_n = 1'b0;
        #2;
        check("mrst_busy", busy, 1'b0);
        check("mrst_ready", snk_ready, 1'b0);
        check("mrst_be", mem_byteenable, 16'h0000);
        check("mrst_data", mem_writedata, 128'h0);
        check("mrst_addr", mem_address, 8'h00);
        check("mrst_clken", mem_clken, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_nwr", wa.size(), 0);

        // Single-beat packet after reset (lane 0 only, byteswapped if enabled)
        clear_log();
        do_start(8'h40);
        send_beat(32'h1122_3344, 1'b1, 0);
        wait_done("one", 9'd1, 1'b0);
        check("one_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            check("one_a0", wa[0], 8'h40);
            check("one_b0", wb[0], 16'h000F);
            check("one_d0", wd[0], {96'h0, ex(32'h1122_3344)});
        end
        check("cs_eq_write", cs_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_onchip_mem_stream_writer
`default_nettype wire

// File: doc/onchip_mem_stream_writer.md
Name: onchip_mem_stream_writer

Overview:
- Upstream feeder for the 128-bit single-port on-chip memory (256 lines, byte-enabled, unregistered read).
- Accepts a 32-bit Avalon-ST packet, packs four beats into one 128-bit line, and writes each line to consecutive memory addresses starting at a programmable base.
- Partial final lines are written with a matching byteenable mask.
- Signals completion with a one-cycle done pulse.

Parameters:
- IN_W, 32, sink data width in bits.
- LINE_W, 128, memory line width; LANES = LINE_W/IN_W = 4.
- ADDR_W, 8, memory address width (256 lines).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a transfer; honoured only in IDLE
- base_addr  in  ADDR_W  first line address, sampled on the accepted start
- snk_valid  in  1  sink beat valid
- snk_ready  out  1  sink ready
- snk_data  in  IN_W  sink beat data
- snk_endofpacket  in  1  marks the last beat of the packet
- mem_address  out  ADDR_W  memory line address
- mem_byteenable  out  LINE_W/8  byte mask for the write
- mem_chipselect  out  1  memory select
- mem_write  out  1  memory write strobe
- mem_writedata  out  LINE_W  packed line data
- mem_clken  out  1  memory clock enable; constant 1 after reset
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- lines_written  out  ADDR_W+1  lines written in the current or last transfer
- wrapped  out  1  sticky flag: address wrapped from 255 to 0 during the transfer

Behaviour:
- Reset values: all outputs 0 except mem_clken=1.
- Reset mid-transfer discards the partial line and returns the FSM to IDLE; no write is issued.
- States are IDLE, FILL, WRITE, DONE.
- IDLE:
  - snk_ready=0.
  - On start: load addr=base_addr, lane=0, mask=0; clear lines_written and wrapped; go to FILL.
- FILL:
  - snk_ready=1.
  - On snk_valid&snk_ready, place the beat at writedata[32*lane+31:32*lane] and set byteenable[4*lane+3:4*lane]=4'hF.
  - If lane==3 or snk_endofpacket: go to WRITE and latch last=snk_endofpacket.
  - Otherwise lane++.
- WRITE:
  - Lasts exactly one cycle with mem_chipselect=mem_write=1; snk_ready=0.
  - mem_address, mem_writedata and mem_byteenable are registered and stable for the whole cycle.
  - On exit: addr++ (modulo 256; set wrapped on the 255->0 transition), lines_written++, clear lane, mask and data.
  - Next state is DONE if last, else FILL.
- DONE: done=1 for one cycle, then IDLE.
- Latency: the line write occurs the cycle after the accepted 4th beat (or the eop beat); done follows one cycle later.
- Throughput: 5 cycles per full line at 100% valid.
- Unused lanes hold writedata=0 with byteenable bits 0.
- mem_chipselect/mem_write are 0 in every state except WRITE.
- start in any non-IDLE state is ignored.
- snk_valid while snk_ready=0 causes no state change.
- eop coinciding with lane 3 produces a single full write, then DONE.
- A packet longer than 256 lines keeps writing with a wrapping address; wrapped=1 and lines_written saturates at 511 (never rolls over).

Optional Feature:
- Macro ONCHIP_WR_BYTESWAP_EN.
- Defined: each accepted 32-bit beat is byte-reversed before packing ({d[7:0],d[15:8],d[23:16],d[31:24]}), giving big-endian sources a little-endian memory image.
- Undefined: beats are packed unchanged.
- Timing and byteenable are identical in both builds.

Decomposition:
- Shared package onchip_wr_pkg holds:
  - state enum (IDLE, FILL, WRITE, DONE)
  - constants IN_W, LINE_W, LANES=4, BE_W=16, ADDR_W=8, MAX_LINES=256
- Natural sub-module: onchip_wr_line_packer.
  - Contains the lane counter, data/byteenable assembly and optional byteswap.
  - Its outputs are line_full, line_data and line_be.
- The FSM, address counter and status registers stay in the top module.

Test Plan:
- Full lines:
  - Stimulus: start with base_addr=8'h10, then 8 beats 32'h0..32'h7 with eop on beat 7.
  - Required: two writes, addr 10 data 00000003_00000002_00000001_00000000 be FFFF, then addr 11 data 7_6_5_4 be FFFF.
  - Required after the second write: done pulse, lines_written=2, wrapped=0.
- Partial line:
  - Stimulus: 6 beats, eop on beat 5, base 0.
  - Required: second write at addr 1 with be=16'h00FF and upper 64 data bits =0.
- Wrap:
  - Stimulus: base_addr=8'hFF, 8 beats.
  - Required: writes at FF then 00, wrapped=1, lines_written=2.
- Backpressure/gaps and ignored start:
  - Stimulus: snk_valid toggled 1-0-1-0; start pulsed mid-transfer.
  - Required: beats packed in order, start ignored, no extra writes, snk_ready=0 during the WRITE cycle.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 after 2 beats.
  - Required: no mem_write, outputs at reset values, next start begins cleanly at the new base.
- Byteswap:
  - Build with ONCHIP_WR_BYTESWAP_EN defined.
  - Stimulus: beat 32'h11223344, eop.
  - Required: line lane 0 = 32'h44332211, be=16'h000F.
